fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
- Top-level controller for one FFT frame in the spectrum analyzer.
- When the capture buffer reports a full frame, it runs the engines in order: bit-reverse reorder, then LOG2N butterfly stages, then the display/magnitude pass.
- Drives each engine with a one-cycle start pulse and waits for that engine's done/tc.
- Sits between the sample-capture block and the existing bit-reverse, butterfly and display engines.

Parameters:
- LOG2N, 9, log2 of FFT size (512 points); equals the number of butterfly stages.
- STG_W, 4, width of the stage index; must satisfy 2^STG_W > LOG2N-1.
- TIMEOUT_CYCLES, 4096, watchdog limit per wait phase (used only with FFT_SEQ_WDOG_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_ready  in  1  level; capture buffer holds a complete frame.
- frame_ack  out  1  one-cycle pulse; frame accepted, capture may refill.
- abort  in  1  level; cancels the frame in progress.
- bitrev_start  out  1  one-cycle start pulse to the bit-reverse engine.
- bitrev_tc  in  1  bit-reverse engine terminal count (done).
- bfly_start  out  1  one-cycle start pulse to the butterfly engine.
- bfly_stage  out  STG_W  current stage index, 0..LOG2N-1.
- bfly_done  in  1  butterfly stage complete.
- disp_start  out  1  one-cycle start pulse to the display pass.
- disp_done  in  1  display pass complete.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_count  out  16  number of completed frames; wraps.
- seq_err  out  1  watchdog error flag, sticky.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All pulse outputs, busy and seq_err are 0.
  - bfly_stage=0, frame_count=0.
- States: IDLE, BR_GO, BR_WAIT, BF_GO, BF_WAIT, DS_GO, DS_WAIT, FIN, ERR.
- All outputs are registered Moore outputs decoded from state.
- Each start pulse is high exactly during its *_GO state, which lasts one cycle.
- IDLE -> BR_GO when frame_ready=1.
  - frame_ack and bitrev_start are both high in BR_GO.
  - Latency from frame_ready sampled high to bitrev_start high is 1 cycle.
- BR_GO -> BR_WAIT unconditionally.
  - Done inputs are ignored in every *_GO state, including a done arriving in that same cycle.
- BR_WAIT -> BF_GO on bitrev_tc=1, with bfly_stage=0.
- BF_GO -> BF_WAIT unconditionally. bfly_stage is held stable through BF_GO and BF_WAIT.
- BF_WAIT on bfly_done=1:
  - If bfly_stage==LOG2N-1, go to DS_GO and clear bfly_stage to 0.
  - Otherwise increment bfly_stage and go to BF_GO.
- DS_GO -> DS_WAIT unconditionally.
- DS_WAIT -> FIN on disp_done=1.
- FIN: frame_done=1, frame_count increments (0xFFFF wraps to 0x0000), then -> IDLE.
- Back-to-back frames: IDLE spends at least 1 cycle, so frame_done to the next bitrev_start is 2 cycles.
- abort:
  - In any state other than IDLE or ERR, abort=1 forces IDLE on the next edge.
  - Abort wins over a simultaneous done.
  - No frame_done pulse; frame_count unchanged; bfly_stage cleared to 0.
  - abort is ignored in IDLE.
- frame_ready is not examined outside IDLE.
- Done pulses arriving in a state that does not expect them are ignored; there is no queueing.
- Reset mid-frame: immediate return to reset values; the engines are reset by their own resets.

Optional Feature:
- Macro: FFT_SEQ_WDOG_EN.
- Defined:
  - A counter clears on entry to each *_WAIT state and increments every cycle while waiting.
  - If it reaches TIMEOUT_CYCLES with no done, the next state is ERR and seq_err is set.
  - ERR holds busy=1 until abort=1, then -> IDLE with seq_err cleared.
  - A done arriving in the same cycle as the timeout wins and is taken.
- Undefined:
  - No counter is built and seq_err is tied to 0.
  - WAIT states wait indefinitely and ERR is unreachable.

Decomposition:
- Package fft_seq_pkg holds:
  - the state enum;
  - LOG2N and STG_W defaults;
  - the TIMEOUT_CYCLES default;
  - the counter width WD_W = clog2(TIMEOUT_CYCLES+1).
- One sub-module, fft_seq_watchdog:
  - inputs: clear, enable;
  - output: expired;
  - instantiated only under FFT_SEQ_WDOG_EN.

Test Plan:
- Nominal frame, LOG2N=3:
  - Stimulus: frame_ready=1; tc 5 cycles after bitrev_start; each bfly_done 4 cycles after its start; disp_done 6 cycles after its start.
  - Required: frame_ack+bitrev_start 1 cycle after frame_ready; bfly_stage 0,1,2 with three bfly_start pulses; one disp_start; one frame_done; frame_count=1.
- Back-to-back frames: frame_ready held high for 3 frames -> frame_count=3; exactly 2 cycles from each frame_done to the next bitrev_start.
- Abort: abort pulsed in BF_WAIT at stage 1 -> IDLE next cycle; bfly_stage=0; no frame_done; frame_count unchanged; a later frame completes normally.
- Edge cases:
  - bitrev_tc high in the BR_GO cycle is ignored; the sequencer stays in BR_WAIT until the next tc.
  - abort together with disp_done -> IDLE, no frame_done.
- Watchdog (FFT_SEQ_WDOG_EN, TIMEOUT_CYCLES=16): withhold bfly_done -> seq_err=1 exactly 16 cycles after BF_WAIT entry; abort -> IDLE with seq_err=0.
- Reset: reset_n low mid-DS_WAIT -> outputs at reset values asynchronously; after release, a frame completes with frame_count=1.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
// The watchdog counter width is derived from the timeout.
package fft_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    BR_GO,
    BR_WAIT,
    BF_GO,
    BF_WAIT,
    DS_GO,
    DS_WAIT,
    FIN,
    ERR
  } seq_state_t;

  localparam int LOG2N_DEF   = 9;
  localparam int STG_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 4096;
  localparam int WD_W        = $clog2(TIMEOUT_DEF + 1);

  function automatic int wd_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fft_seq_watchdog.sv
// Per-phase wait counter for the FFT frame sequencer.
// Flags expiry on the last waiting cycle before TIMEOUT is reached.
module fft_seq_watchdog
  import fft_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int W       = WD_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: bit-reverse, LOG2N butterfly stages, display pass.
// Define FFT_SEQ_WDOG_EN to build the per-phase watchdog and ERR state.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int LOG2N          = LOG2N_DEF,
  parameter int STG_W          = STG_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             frame_ready,
  output logic             frame_ack,
  input  logic             abort,
  output logic             bitrev_start,
  input  logic             bitrev_tc,
  output logic             bfly_start,
  output logic [STG_W-1:0] bfly_stage,
  input  logic             bfly_done,
  output logic             disp_start,
  input  logic             disp_done,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             seq_err
);

  if ((1 << STG_W) <= (LOG2N - 1)) begin : g_stg_chk
    $error("STG_W too narrow for LOG2N");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("TIMEOUT_CYCLES must be positive");
  end

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);

  seq_state_t       state, state_n;
  logic [STG_W-1:0] stage_n;
  logic             expired;

`ifdef FFT_SEQ_WDOG_EN
  localparam int WDW = wd_width(TIMEOUT_CYCLES);

  logic waiting;
  logic err_q;

  assign waiting = (state == BR_WAIT) ||
                   (state == BF_WAIT) ||
                   (state == DS_WAIT);

  fft_seq_watchdog #(
    .TIMEOUT (TIMEOUT_CYCLES),
    .W       (WDW)
  ) u_wdog (
    .clk     (Clk),
    .rst_n   (reset_n),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= (state_n == ERR);
  end

  assign seq_err = err_q;
`else
  assign expired = 1'b0;
  assign seq_err = 1'b0;
`endif

  // A done on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_n = state;
    stage_n = bfly_stage;
    unique case (state)
      IDLE:    if (frame_ready) state_n = BR_GO;
      BR_GO:   state_n = BR_WAIT;
      BR_WAIT: begin
        if (bitrev_tc)    state_n = BF_GO;
        else if (expired) state_n = ERR;
      end
      BF_GO:   state_n = BF_WAIT;
      BF_WAIT: begin
        if (bfly_done) begin
          if (bfly_stage == LAST_STG) begin
            state_n = DS_GO;
            stage_n = '0;
          end else begin
            state_n = BF_GO;
            stage_n = bfly_stage + 1'b1;
          end
        end else if (expired) begin
          state_n = ERR;
        end
      end
      DS_GO:   state_n = DS_WAIT;
      DS_WAIT: begin
        if (disp_done)    state_n = FIN;
        else if (expired) state_n = ERR;
      end
      FIN:     state_n = IDLE;
      ERR:     if (abort) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE && state != ERR) begin
      state_n = IDLE;
      stage_n = '0;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bfly_stage   <= '0;
      frame_ack    <= 1'b0;
      bitrev_start <= 1'b0;
      bfly_start   <= 1'b0;
      disp_start   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_n;
      bfly_stage   <= stage_n;
      frame_ack    <= (state_n == BR_GO);
      bitrev_start <= (state_n == BR_GO);
      bfly_start   <= (state_n == BF_GO);
      disp_start   <= (state_n == DS_GO);
      busy         <= (state_n != IDLE);
      frame_done   <= (state_n == FIN);
      if (state_n == FIN) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
